// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light front end and controller.
//   MODE_*     : 2-bit start-mode encoding carried by start_mode
//   cnt_width  : width of a counter that spans 0..n-1 (minimum 1 bit)
package traffic_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STOP = 2'b00;
  localparam mode_t MODE_HOLD = 2'b01;
  localparam mode_t MODE_GO   = 2'b10;
  localparam mode_t MODE_SLOW = 2'b11;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability debouncer for one raw input.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   din   : raw input, asynchronous to clk
//   dout  : debounced level; changes only after the synchronised input has
//           disagreed with it for DB_CYCLES consecutive cycles
// All three flops reset to RESET_VAL so a released key does not produce an
// edge when reset lifts.
module debounce_sync #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  import traffic_pkg::*;

  localparam int unsigned CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Any cycle of agreement restarts the run, so short glitches are dropped.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/traffic_input_conditioner.sv
// Input front end for the traffic-light controller.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   key_pause_n : raw pause pushbutton (active-low)
//   key_rst_n   : raw controller-reset pushbutton (active-low)
//   sw_raw      : raw slide switches
//   sw_clean    : debounced switch levels
//   pause_pulse : one-cycle pulse per accepted pause press
//   paused      : pause state, toggles the cycle after each pause_pulse
//   ctrl_reset  : active-high synchronous reset for the controller, stretched
//   start_mode  : sw_clean[9:8] latched when the controller reset is triggered
//   tick        : one-cycle pulse every TICK_CYCLES unpaused, unreset cycles
// N_SW must be at least 10 since the start mode is taken from switches 9:8.
module traffic_input_conditioner #(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned N_SW        = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_pause_n,
  input  logic            key_rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic            pause_pulse,
  output logic            paused,
  output logic            ctrl_reset,
  output logic [1:0]      start_mode,
  output logic            tick
);

  import traffic_pkg::*;

  localparam int unsigned MODE_LSB = 8;

  localparam int unsigned HOLD_W = cnt_width(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  localparam int unsigned TICK_W = cnt_width(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  // Debounced inputs

  logic pause_db, rst_db;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_sync #(
      .DB_CYCLES(DB_CYCLES),
      .RESET_VAL(1'b0)
    ) u_db_sw (
      .clk  (clk),
      .reset(reset),
      .din  (sw_raw[i]),
      .dout (sw_clean[i])
    );
  end

  debounce_sync #(
    .DB_CYCLES(DB_CYCLES),
    .RESET_VAL(1'b1)
  ) u_db_pause (
    .clk  (clk),
    .reset(reset),
    .din  (key_pause_n),
    .dout (pause_db)
  );

  debounce_sync #(
    .DB_CYCLES(DB_CYCLES),
    .RESET_VAL(1'b1)
  ) u_db_rst (
    .clk  (clk),
    .reset(reset),
    .din  (key_rst_n),
    .dout (rst_db)
  );

  // State

  logic              pause_db_q, rst_db_q;
  logic              ctrl_reset_q, ctrl_reset_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  mode_t             start_mode_q, start_mode_d;
  logic              paused_q, paused_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;

  logic pause_fall, rst_fall, hold_clear;

  always_comb begin
    pause_fall = pause_db_q & ~pause_db;
    rst_fall   = rst_db_q & ~rst_db;
    // Presses landing inside a hold are swallowed, not deferred.
    pause_pulse = pause_fall & ~ctrl_reset_q;
    // Include the trigger cycle so paused/tick are already clear when
    // ctrl_reset rises, even if a pause press or wrap coincides with it.
    hold_clear = ctrl_reset_q | rst_fall;
  end

  // Reset stretcher; a fresh trigger restarts the hold and relatches the mode.
  always_comb begin
    ctrl_reset_d = ctrl_reset_q;
    hold_cnt_d   = hold_cnt_q;
    start_mode_d = start_mode_q;
    if (rst_fall) begin
      ctrl_reset_d = 1'b1;
      hold_cnt_d   = '0;
      start_mode_d = sw_clean[MODE_LSB +: 2];
    end else if (ctrl_reset_q) begin
      if (hold_cnt_q == HOLD_MAX) begin
        ctrl_reset_d = 1'b0;
        hold_cnt_d   = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
      end
    end
  end

  // Pause toggle and phase tick. The tick counter holds while paused so a
  // resume carries on from the same phase.
  always_comb begin
    paused_d   = hold_clear ? 1'b0 : (paused_q ^ pause_pulse);
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    if (hold_clear) begin
      tick_cnt_d = '0;
    end else if (!paused_q) begin
      if (tick_cnt_q == TICK_MAX) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_db_q   <= 1'b1;
      rst_db_q     <= 1'b1;
      ctrl_reset_q <= 1'b1;
      hold_cnt_q   <= '0;
      start_mode_q <= MODE_STOP;
      paused_q     <= 1'b0;
      tick_cnt_q   <= '0;
      tick_q       <= 1'b0;
    end else begin
      pause_db_q   <= pause_db;
      rst_db_q     <= rst_db;
      ctrl_reset_q <= ctrl_reset_d;
      hold_cnt_q   <= hold_cnt_d;
      start_mode_q <= start_mode_d;
      paused_q     <= paused_d;
      tick_cnt_q   <= tick_cnt_d;
      tick_q       <= tick_d;
    end
  end

  assign paused     = paused_q;
  assign ctrl_reset = ctrl_reset_q;
  assign start_mode = start_mode_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner with DB_CYCLES=4, TICK_CYCLES=10,
// RST_HOLD=3. A second instance with a 16-cycle hold shares every input so a
// second debounced reset press can land inside a running hold.
// Comments "E<n>" name the state just after the n-th clock edge following the
// first reset release.
module tb_traffic_input_conditioner;

  logic       clk;
  logic       reset;
  logic       key_pause_n;
  logic       key_rst_n;
  logic [9:0] sw_raw;

  logic [9:0] sw_clean, sw_clean_l;
  logic       pause_pulse, pause_pulse_l;
  logic       paused, paused_l;
  logic       ctrl_reset, ctrl_reset_l;
  logic [1:0] start_mode, start_mode_l;
  logic       tick, tick_l;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_seen  = 0;
  int tick_seen   = 0;

  traffic_input_conditioner #(
    .DB_CYCLES  (4),
    .TICK_CYCLES(10),
    .RST_HOLD   (3),
    .N_SW       (10)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .key_pause_n(key_pause_n),
    .key_rst_n  (key_rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .pause_pulse(pause_pulse),
    .paused     (paused),
    .ctrl_reset (ctrl_reset),
    .start_mode (start_mode),
    .tick       (tick)
  );

  traffic_input_conditioner #(
    .DB_CYCLES  (4),
    .TICK_CYCLES(10),
    .RST_HOLD   (16),
    .N_SW       (10)
  ) u_dut_long (
    .clk        (clk),
    .reset      (reset),
    .key_pause_n(key_pause_n),
    .key_rst_n  (key_rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean_l),
    .pause_pulse(pause_pulse_l),
    .paused     (paused_l),
    .ctrl_reset (ctrl_reset_l),
    .start_mode (start_mode_l),
    .tick       (tick_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pause_pulse === 1'b1) pulse_seen <= pulse_seen + 1;
    if (tick === 1'b1) tick_seen <= tick_seen + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] modes [4];
  logic [9:0] swv;

  initial begin
    modes[0] = 2'b01;
    modes[1] = 2'b10;
    modes[2] = 2'b11;
    modes[3] = 2'b00;

    reset = 1'b0; key_pause_n = 1'b1; key_rst_n = 1'b1; sw_raw = '0;
    cyc(2);
    chk("rst_ctrl_reset", ctrl_reset, 1);
    chk("rst_paused", paused, 0);
    chk("rst_tick", tick, 0);
    chk("rst_sw_clean", sw_clean, 0);
    chk("rst_start_mode", start_mode, 0);
    chk("rst_pause_pulse", pause_pulse, 0);
    chk("rst_ctrl_reset_long", ctrl_reset_l, 1);

    // Power-on hold: 3 cycles, then the tick counter starts.
    reset = 1'b1;
    cyc(1); chk("por_hold_e0", ctrl_reset, 1);
    cyc(1); chk("por_hold_e1", ctrl_reset, 1);
    cyc(1); chk("por_hold_e2", ctrl_reset, 0);
    cyc(9); chk("tick_e11", tick, 0);
    cyc(1); chk("tick_e12", tick, 1);
    chk("por_long_e12", ctrl_reset_l, 1);
    cyc(1); chk("tick_e13", tick, 0);
    cyc(9); chk("tick_e22", tick, 1);
    chk("por_long_e22", ctrl_reset_l, 0);

    // 3-cycle pause glitch is filtered.
    key_pause_n = 1'b0; cyc(3);
    key_pause_n = 1'b1; cyc(6);                  // E31
    chk("glitch_pulses", pulse_seen, 0);
    chk("glitch_paused", paused, 0);

    // Long press: pulse 6 cycles after the fall, then paused, ticks stop.
    key_pause_n = 1'b0;
    cyc(5); chk("press_e36_pulse", pause_pulse, 0);
    cyc(1); chk("press_e37_pulse", pause_pulse, 1);
    chk("press_e37_paused", paused, 0);
    cyc(1); chk("press_e38_paused", paused, 1);
    chk("press_e38_pulse", pause_pulse, 0);
    chk("press_pulses", pulse_seen, 1);
    chk("ticks_before_pause", tick_seen, 3);
    cyc(13); key_pause_n = 1'b1;                 // E51, release
    cyc(10);                                     // E61
    chk("paused_ticks", tick_seen, 3);
    chk("release_no_pulse", pulse_seen, 1);
    chk("still_paused", paused, 1);

    // Second press resumes from the held count (6): tick 4 cycles later.
    key_pause_n = 1'b0;
    cyc(6); chk("resume_e67_pulse", pause_pulse, 1);
    cyc(1); chk("resume_e68_paused", paused, 0);
    key_pause_n = 1'b1;
    cyc(3); chk("resume_e71_tick", tick, 0);
    cyc(1); chk("resume_e72_tick", tick, 1);
    cyc(8);                                      // E80

    // Controller reset with each start mode; pause first so the clear shows.
    for (int i = 0; i < 4; i++) begin
      swv = {modes[i], 8'hA5 ^ 8'(i)};
      sw_raw = swv; key_pause_n = 1'b0;
      cyc(6); chk("blk_pause_pulse", pause_pulse, 1);
      cyc(2); chk("blk_sw_clean", sw_clean, swv);
      chk("blk_paused_set", paused, 1);
      key_pause_n = 1'b1; key_rst_n = 1'b0;
      cyc(7); chk("blk_ctrl_on", ctrl_reset, 1);
      chk("blk_start_mode", start_mode, modes[i]);
      chk("blk_paused_clr", paused, 0);
      chk("blk_tick_off", tick, 0);
      cyc(2); chk("blk_ctrl_last", ctrl_reset, 1);
      key_rst_n = 1'b1;
      cyc(1); chk("blk_ctrl_off", ctrl_reset, 0);
      cyc(6);
    end                                          // E176

    // Pause edge inside the hold is discarded.
    key_rst_n = 1'b0;
    cyc(2); key_pause_n = 1'b0;
    cyc(6); chk("inhold_ctrl", ctrl_reset, 1);
    chk("inhold_pulse", pause_pulse, 0);
    key_rst_n = 1'b1;
    cyc(4); key_pause_n = 1'b1;
    cyc(12);                                     // E200
    chk("inhold_pulses", pulse_seen, 6);
    chk("inhold_paused", paused, 0);

    // Re-trigger during a running hold (16-cycle instance), mode 11 -> 10.
    sw_raw = {2'b11, 8'h3C};
    cyc(8); chk("rt_sw_clean", sw_clean, {2'b11, 8'h3C});
    key_rst_n = 1'b0;                            // E208
    cyc(6); key_rst_n = 1'b1; sw_raw = {2'b10, 8'h3C};
    cyc(1);                                      // E215
    chk("rt_long_on", ctrl_reset_l, 1);
    chk("rt_long_mode1", start_mode_l, 2'b11);
    chk("rt_mode1", start_mode, 2'b11);
    cyc(5); key_rst_n = 1'b0;                    // E220
    cyc(6); chk("rt_long_mode_hold", start_mode_l, 2'b11);
    cyc(1);                                      // E227
    chk("rt_long_mode2", start_mode_l, 2'b10);
    chk("rt_mode2", start_mode, 2'b10);
    chk("rt_ctrl_again", ctrl_reset, 1);
    key_rst_n = 1'b1;
    cyc(4); chk("rt_long_restarted", ctrl_reset_l, 1);
    chk("rt_ctrl_done", ctrl_reset, 0);
    cyc(11); chk("rt_long_e242", ctrl_reset_l, 1);
    cyc(1); chk("rt_long_e243", ctrl_reset_l, 0);
    cyc(2);                                      // E245

    // Pause, then pull reset mid-count: everything returns at once.
    key_pause_n = 1'b0;
    cyc(6); chk("ar_pulse", pause_pulse, 1);
    cyc(1); chk("ar_paused", paused, 1);
    key_pause_n = 1'b1;
    cyc(10);
    #2 reset = 1'b0;
    #1;
    chk("ar_sw_clean", sw_clean, 0);
    chk("ar_paused0", paused, 0);
    chk("ar_tick", tick, 0);
    chk("ar_start_mode", start_mode, 0);
    chk("ar_ctrl_reset", ctrl_reset, 1);
    chk("ar_pause_pulse", pause_pulse, 0);
    chk("ar_long_mode", start_mode_l, 0);
    cyc(2);
    reset = 1'b1;
    cyc(1); chk("ar_hold_e0", ctrl_reset, 1);
    cyc(1); chk("ar_hold_e1", ctrl_reset, 1);
    cyc(1); chk("ar_hold_e2", ctrl_reset, 0);
    cyc(2); chk("ar_sw_e4", sw_clean, 0);
    cyc(1); chk("ar_sw_e5", sw_clean, {2'b10, 8'h3C});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
